// File: rtl/peripheral_mpram_axi4_pkg.sv
// Shared AXI4 encodings and bridge state set for the MPRAM AXI4 initiator/responder pair.
package peripheral_mpram_axi4_pkg;

  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RESP,
    RD_REQ,
    RD_RESP
  } state_e;

endpackage

// File: rtl/peripheral_mpram_master_axi4.sv
// AXI4 initiator: turns a req/gnt memory port into single-beat AXI4 reads/writes, one outstanding.
//
// state   | meaning
// IDLE    | waiting for req_i, gnt_o asserted combinationally
// WR_REQ  | AW and W offered, each retired independently
// WR_RESP | b_ready high, waiting for the write response
// RD_REQ  | AR offered
// RD_RESP | r_ready high, waiting for the read beat
module peripheral_mpram_master_axi4
  import peripheral_mpram_axi4_pkg::*;
#(
  parameter int AXI_ID_WIDTH   = 10,
  parameter int AXI_ADDR_WIDTH = 64,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_STRB_WIDTH = 8,
  parameter int AXI_USER_WIDTH = 10,
  parameter logic [AXI_ID_WIDTH-1:0] TXN_ID = '0
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      req_i,
  input  logic                      we_i,
  input  logic [AXI_ADDR_WIDTH-1:0] addr_i,
  input  logic [AXI_STRB_WIDTH-1:0] be_i,
  input  logic [AXI_DATA_WIDTH-1:0] data_i,
  output logic                      gnt_o,
  output logic                      rvalid_o,
  output logic [AXI_DATA_WIDTH-1:0] data_o,
  output logic                      err_o,

  output logic [AXI_ID_WIDTH-1:0]   axi_aw_id,
  output logic [AXI_ADDR_WIDTH-1:0] axi_aw_addr,
  output logic [7:0]                axi_aw_len,
  output logic [2:0]                axi_aw_size,
  output logic [1:0]                axi_aw_burst,
  output logic                      axi_aw_lock,
  output logic [3:0]                axi_aw_cache,
  output logic [2:0]                axi_aw_prot,
  output logic [3:0]                axi_aw_qos,
  output logic [3:0]                axi_aw_region,
  output logic [AXI_USER_WIDTH-1:0] axi_aw_user,
  output logic                      axi_aw_valid,
  input  logic                      axi_aw_ready,

  output logic [AXI_ID_WIDTH-1:0]   axi_ar_id,
  output logic [AXI_ADDR_WIDTH-1:0] axi_ar_addr,
  output logic [7:0]                axi_ar_len,
  output logic [2:0]                axi_ar_size,
  output logic [1:0]                axi_ar_burst,
  output logic                      axi_ar_lock,
  output logic [3:0]                axi_ar_cache,
  output logic [2:0]                axi_ar_prot,
  output logic [3:0]                axi_ar_qos,
  output logic [3:0]                axi_ar_region,
  output logic [AXI_USER_WIDTH-1:0] axi_ar_user,
  output logic                      axi_ar_valid,
  input  logic                      axi_ar_ready,

  output logic [AXI_DATA_WIDTH-1:0] axi_w_data,
  output logic [AXI_STRB_WIDTH-1:0] axi_w_strb,
  output logic                      axi_w_last,
  output logic [AXI_USER_WIDTH-1:0] axi_w_user,
  output logic                      axi_w_valid,
  input  logic                      axi_w_ready,

  input  logic [AXI_ID_WIDTH-1:0]   axi_r_id,
  input  logic [AXI_DATA_WIDTH-1:0] axi_r_data,
  input  logic [1:0]                axi_r_resp,
  input  logic                      axi_r_last,
  input  logic [AXI_USER_WIDTH-1:0] axi_r_user,
  input  logic                      axi_r_valid,
  output logic                      axi_r_ready,

  input  logic [AXI_ID_WIDTH-1:0]   axi_b_id,
  input  logic [1:0]                axi_b_resp,
  input  logic [AXI_USER_WIDTH-1:0] axi_b_user,
  input  logic                      axi_b_valid,
  output logic                      axi_b_ready
);

  localparam logic [2:0] AXI_SIZE = 3'($clog2(AXI_STRB_WIDTH));

  state_e                    state;
  logic [AXI_ADDR_WIDTH-1:0] addr_q;
  logic [AXI_DATA_WIDTH-1:0] data_q;
  logic [AXI_STRB_WIDTH-1:0] strb_q;
  logic [AXI_DATA_WIDTH-1:0] rdata_q;
  logic aw_valid_q, w_valid_q, ar_valid_q, b_ready_q, r_ready_q;
  logic rvalid_q, err_q;

  logic aw_hs, w_hs, ar_hs, b_hs, r_hs;
  logic aw_done, w_done;

  assign aw_hs = aw_valid_q & axi_aw_ready;
  assign w_hs  = w_valid_q & axi_w_ready;
  assign ar_hs = ar_valid_q & axi_ar_ready;
  assign b_hs  = b_ready_q & axi_b_valid;
  assign r_hs  = r_ready_q & axi_r_valid;

  // In WR_REQ a channel is done once its valid has dropped or is handshaking now.
  assign aw_done = aw_hs | ~aw_valid_q;
  assign w_done  = w_hs | ~w_valid_q;

  assign gnt_o = req_i && (state == IDLE);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= IDLE;
      addr_q     <= '0;
      data_q     <= '0;
      strb_q     <= '0;
      rdata_q    <= '0;
      aw_valid_q <= 1'b0;
      w_valid_q  <= 1'b0;
      ar_valid_q <= 1'b0;
      b_ready_q  <= 1'b0;
      r_ready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      case (state)
        IDLE: begin
          if (req_i) begin
            addr_q <= addr_i;
            data_q <= data_i;
            strb_q <= be_i;
            if (we_i) begin
              state      <= WR_REQ;
              aw_valid_q <= 1'b1;
              w_valid_q  <= 1'b1;
            end else begin
              state      <= RD_REQ;
              ar_valid_q <= 1'b1;
            end
          end
        end
        WR_REQ: begin
          if (aw_hs) aw_valid_q <= 1'b0;
          if (w_hs)  w_valid_q  <= 1'b0;
          if (aw_done && w_done) begin
            state     <= WR_RESP;
            b_ready_q <= 1'b1;
          end
        end
        WR_RESP: begin
          if (b_hs) begin
            state     <= IDLE;
            b_ready_q <= 1'b0;
            rvalid_q  <= 1'b1;
            err_q     <= axi_b_resp[1];
          end
        end
        RD_REQ: begin
          if (ar_hs) begin
            state      <= RD_RESP;
            ar_valid_q <= 1'b0;
            r_ready_q  <= 1'b1;
          end
        end
        RD_RESP: begin
          if (r_hs) begin
            state     <= IDLE;
            r_ready_q <= 1'b0;
            rdata_q   <= axi_r_data;
            rvalid_q  <= 1'b1;
            err_q     <= axi_r_resp[1] | ~axi_r_last;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign rvalid_o = rvalid_q;
  assign err_o    = err_q;
  assign data_o   = rdata_q;

  assign axi_aw_id     = TXN_ID;
  assign axi_aw_addr   = addr_q;
  assign axi_aw_len    = 8'd0;
  assign axi_aw_size   = AXI_SIZE;
  assign axi_aw_burst  = BURST_INCR;
  assign axi_aw_lock   = 1'b0;
  assign axi_aw_cache  = 4'b0000;
  assign axi_aw_prot   = 3'b000;
  assign axi_aw_qos    = 4'd0;
  assign axi_aw_region = 4'd0;
  assign axi_aw_user   = '0;
  assign axi_aw_valid  = aw_valid_q;

  assign axi_ar_id     = TXN_ID;
  assign axi_ar_addr   = addr_q;
  assign axi_ar_len    = 8'd0;
  assign axi_ar_size   = AXI_SIZE;
  assign axi_ar_burst  = BURST_INCR;
  assign axi_ar_lock   = 1'b0;
  assign axi_ar_cache  = 4'b0000;
  assign axi_ar_prot   = 3'b000;
  assign axi_ar_qos    = 4'd0;
  assign axi_ar_region = 4'd0;
  assign axi_ar_user   = '0;
  assign axi_ar_valid  = ar_valid_q;

  assign axi_w_data  = data_q;
  assign axi_w_strb  = strb_q;
  assign axi_w_last  = 1'b1;
  assign axi_w_user  = '0;
  assign axi_w_valid = w_valid_q;

  assign axi_b_ready = b_ready_q;
  assign axi_r_ready = r_ready_q;

  // IDs, user fields and the low response bits carry nothing this initiator acts on.
  logic unused_inputs;
  assign unused_inputs = ^{axi_r_id, axi_r_user, axi_b_id, axi_b_user, axi_r_resp[0], axi_b_resp[0]};

endmodule

// File: tb/tb_peripheral_mpram_master_axi4.sv
// Directed bench for the AXI4 initiator against a small behavioural AXI4 memory slave.
module tb_peripheral_mpram_master_axi4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        req = 1'b0, we = 1'b0;
  logic [63:0] addr = '0, wdata = '0;
  logic [7:0]  be = '0;
  logic        gnt, rvalid, err;
  logic [63:0] rdata;

  logic [9:0]  axi_aw_id, axi_ar_id;
  logic [63:0] axi_aw_addr, axi_ar_addr;
  logic [7:0]  axi_aw_len, axi_ar_len;
  logic [2:0]  axi_aw_size, axi_ar_size, axi_aw_prot, axi_ar_prot;
  logic [1:0]  axi_aw_burst, axi_ar_burst;
  logic        axi_aw_lock, axi_ar_lock;
  logic [3:0]  axi_aw_cache, axi_ar_cache, axi_aw_qos, axi_ar_qos, axi_aw_region, axi_ar_region;
  logic [9:0]  axi_aw_user, axi_ar_user, axi_w_user;
  logic        axi_aw_valid, axi_ar_valid, axi_w_valid, axi_w_last, axi_r_ready, axi_b_ready;
  logic [63:0] axi_w_data;
  logic [7:0]  axi_w_strb;

  logic        axi_aw_ready = 1'b0, axi_ar_ready = 1'b0, axi_w_ready = 1'b0;
  logic        axi_r_valid = 1'b0, axi_r_last = 1'b0, axi_b_valid = 1'b0;
  logic [63:0] axi_r_data = '0;
  logic [1:0]  axi_r_resp = '0, axi_b_resp = '0;
  logic [9:0]  axi_r_id = '0, axi_b_id = '0, axi_r_user = '0, axi_b_user = '0;

  peripheral_mpram_master_axi4 dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_i(req), .we_i(we), .addr_i(addr), .be_i(be), .data_i(wdata),
    .gnt_o(gnt), .rvalid_o(rvalid), .data_o(rdata), .err_o(err),
    .axi_aw_id(axi_aw_id), .axi_aw_addr(axi_aw_addr), .axi_aw_len(axi_aw_len),
    .axi_aw_size(axi_aw_size), .axi_aw_burst(axi_aw_burst), .axi_aw_lock(axi_aw_lock),
    .axi_aw_cache(axi_aw_cache), .axi_aw_prot(axi_aw_prot), .axi_aw_qos(axi_aw_qos),
    .axi_aw_region(axi_aw_region), .axi_aw_user(axi_aw_user), .axi_aw_valid(axi_aw_valid),
    .axi_aw_ready(axi_aw_ready),
    .axi_ar_id(axi_ar_id), .axi_ar_addr(axi_ar_addr), .axi_ar_len(axi_ar_len),
    .axi_ar_size(axi_ar_size), .axi_ar_burst(axi_ar_burst), .axi_ar_lock(axi_ar_lock),
    .axi_ar_cache(axi_ar_cache), .axi_ar_prot(axi_ar_prot), .axi_ar_qos(axi_ar_qos),
    .axi_ar_region(axi_ar_region), .axi_ar_user(axi_ar_user), .axi_ar_valid(axi_ar_valid),
    .axi_ar_ready(axi_ar_ready),
    .axi_w_data(axi_w_data), .axi_w_strb(axi_w_strb), .axi_w_last(axi_w_last),
    .axi_w_user(axi_w_user), .axi_w_valid(axi_w_valid), .axi_w_ready(axi_w_ready),
    .axi_r_id(axi_r_id), .axi_r_data(axi_r_data), .axi_r_resp(axi_r_resp),
    .axi_r_last(axi_r_last), .axi_r_user(axi_r_user), .axi_r_valid(axi_r_valid),
    .axi_r_ready(axi_r_ready),
    .axi_b_id(axi_b_id), .axi_b_resp(axi_b_resp), .axi_b_user(axi_b_user),
    .axi_b_valid(axi_b_valid), .axi_b_ready(axi_b_ready)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Slave model: decisions made on the falling edge, handshakes land on the next rising edge.
  logic [63:0] mem [logic [63:0]];
  int          aw_stall = 0;
  logic [1:0]  b_resp_cfg = 2'b00, r_resp_cfg = 2'b00;
  logic        r_last_cfg = 1'b1, r_hold = 1'b0;
  logic        aw_got = 0, w_got = 0, ar_got = 0, b_fire = 0, r_fire = 0;
  logic [63:0] aw_addr_cap, w_data_cap, ar_addr_cap;
  logic [7:0]  w_strb_cap;
  int          b_count = 0;

  task automatic slave_reset();
    aw_got = 0; w_got = 0; ar_got = 0; b_fire = 0; r_fire = 0;
    axi_aw_ready = 0; axi_w_ready = 0; axi_ar_ready = 0;
    axi_b_valid = 0; axi_r_valid = 0; r_hold = 0;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (b_fire) begin
          axi_b_valid = 0; b_fire = 0; aw_got = 0; w_got = 0; b_count++;
        end else if (axi_b_valid) begin
          if (axi_b_ready) b_fire = 1;
        end else if (aw_got && w_got) begin
          logic [63:0] cur;
          cur = mem.exists(aw_addr_cap) ? mem[aw_addr_cap] : 64'd0;
          for (int i = 0; i < 8; i++)
            if (w_strb_cap[i]) cur[i*8 +: 8] = w_data_cap[i*8 +: 8];
          mem[aw_addr_cap] = cur;
          axi_b_valid = 1; axi_b_resp = b_resp_cfg;
          if (axi_b_ready) b_fire = 1;
        end

        if (r_fire) begin
          axi_r_valid = 0; r_fire = 0; ar_got = 0;
        end else if (axi_r_valid) begin
          if (axi_r_ready) r_fire = 1;
        end else if (ar_got && !r_hold) begin
          axi_r_valid = 1;
          axi_r_data  = mem.exists(ar_addr_cap) ? mem[ar_addr_cap] : 64'd0;
          axi_r_resp  = r_resp_cfg;
          axi_r_last  = r_last_cfg;
          if (axi_r_ready) r_fire = 1;
        end

        axi_aw_ready = 0;
        if (axi_aw_valid && !aw_got) begin
          if (aw_stall > 0) aw_stall--;
          else begin axi_aw_ready = 1; aw_got = 1; aw_addr_cap = axi_aw_addr; end
        end
        axi_w_ready = 0;
        if (axi_w_valid && !w_got) begin
          axi_w_ready = 1; w_got = 1; w_data_cap = axi_w_data; w_strb_cap = axi_w_strb;
        end
        axi_ar_ready = 0;
        if (axi_ar_valid && !ar_got) begin
          axi_ar_ready = 1; ar_got = 1; ar_addr_cap = axi_ar_addr;
        end
      end
    end
  end

  // Issue one request from IDLE and wait (bounded) for its completion pulse.
  task automatic do_txn(input logic w, input logic [63:0] a, input logic [7:0] b,
                        input logic [63:0] d, output logic [63:0] rd, output logic e);
    bit seen = 0;
    @(negedge clk);
    req = 1; we = w; addr = a; be = b; wdata = d;
    #1 chk("txn_gnt", gnt, 1'b1);
    @(negedge clk);
    req = 0;
    rd = '0; e = 0;
    for (int n = 0; n < 50 && !seen; n++) begin
      @(negedge clk);
      #1;
      if (rvalid) begin seen = 1; rd = rdata; e = err; end
    end
    chk("txn_done", seen, 1'b1);
    @(negedge clk);
    #1 chk("txn_err_clear", {rvalid, err}, 2'b00);
  endtask

  logic [63:0] rd;
  logic        e;

  initial begin
    repeat (2) @(negedge clk);
    #1;
    chk("rst_gnt", gnt, 1'b0);
    chk("rst_valids", {axi_aw_valid, axi_w_valid, axi_ar_valid}, 3'b000);
    chk("rst_readys", {axi_b_ready, axi_r_ready}, 2'b00);
    chk("rst_rvalid_err", {rvalid, err}, 2'b00);
    chk("rst_data", rdata, 64'd0);
    @(negedge clk);
    rst_n = 1;

    // Write with always-ready slave: exact cycle timing.
    @(negedge clk);
    req = 1; we = 1; addr = 64'h40; be = 8'hFF; wdata = 64'hDEADBEEF_CAFEF00D;
    #1 chk("w_gnt_c0", gnt, 1'b1);
    chk("w_aw_c0", axi_aw_valid, 1'b0);
    @(negedge clk);
    req = 0;
    #1 chk("w_valid_c1", {axi_aw_valid, axi_w_valid}, 2'b11);
    chk("w_size", axi_aw_size, 3'd3);
    chk("w_len", axi_aw_len, 8'd0);
    chk("w_burst", axi_aw_burst, 2'b01);
    chk("w_last", axi_w_last, 1'b1);
    chk("w_addr", axi_aw_addr, 64'h40);
    chk("w_data", axi_w_data, 64'hDEADBEEF_CAFEF00D);
    chk("w_strb", axi_w_strb, 8'hFF);
    @(negedge clk);
    #1 chk("w_c2_valid", {axi_aw_valid, axi_w_valid}, 2'b00);
    chk("w_c2_bready", axi_b_ready, 1'b1);
    chk("w_c2_rvalid", rvalid, 1'b0);
    @(negedge clk);
    #1 chk("w_c3_rvalid", {rvalid, err}, 2'b10);
    chk("w_c3_bready", axi_b_ready, 1'b0);
    @(negedge clk);
    #1 chk("w_c4_rvalid", rvalid, 1'b0);

    // Read back with exact timing.
    @(negedge clk);
    req = 1; we = 0; addr = 64'h40;
    #1 chk("r_gnt_c0", gnt, 1'b1);
    @(negedge clk);
    req = 0;
    #1 chk("r_ar_c1", axi_ar_valid, 1'b1);
    chk("r_ar_addr", axi_ar_addr, 64'h40);
    chk("r_ar_size", axi_ar_size, 3'd3);
    @(negedge clk);
    #1 chk("r_c2_rready", {axi_ar_valid, axi_r_ready}, 2'b01);
    @(negedge clk);
    #1 chk("r_c3_rvalid", {rvalid, err}, 2'b10);
    chk("r_c3_data", rdata, 64'hDEADBEEF_CAFEF00D);

    // AW stalled three cycles while W goes through at once.
    aw_stall = 3;
    @(negedge clk);
    req = 1; we = 1; addr = 64'h48; be = 8'h0F; wdata = 64'h11223344_55667788;
    #1 chk("s_gnt", gnt, 1'b1);
    @(negedge clk);
    req = 0;
    #1 chk("s_c1", {axi_aw_valid, axi_w_valid}, 2'b11);
    @(negedge clk);
    #1 chk("s_c2", {axi_aw_valid, axi_w_valid}, 2'b10);
    @(negedge clk);
    #1 chk("s_c3_addr", axi_aw_addr, 64'h48);
    chk("s_c3_bready", axi_b_ready, 1'b0);
    @(negedge clk);
    #1 chk("s_c4", {axi_aw_valid, axi_aw_ready}, 2'b11);
    @(negedge clk);
    #1 chk("s_c5", {axi_aw_valid, axi_b_ready}, 2'b01);
    @(negedge clk);
    #1 chk("s_c6_rvalid", rvalid, 1'b1);
    chk("s_b_count", b_count, 2);
    do_txn(0, 64'h48, 8'h00, 64'd0, rd, e);
    chk("s_readback", rd, 64'h00000000_55667788);

    // Error responses.
    b_resp_cfg = 2'b10;
    do_txn(1, 64'h50, 8'hFF, 64'h0123456789ABCDEF, rd, e);
    chk("err_b_slverr", e, 1'b1);
    b_resp_cfg = 2'b00;
    r_resp_cfg = 2'b11;
    do_txn(0, 64'h50, 8'h00, 64'd0, rd, e);
    chk("err_r_decerr", e, 1'b1);
    chk("err_r_data", rd, 64'h0123456789ABCDEF);
    r_resp_cfg = 2'b00;
    r_last_cfg = 1'b0;
    do_txn(0, 64'h40, 8'h00, 64'd0, rd, e);
    chk("err_r_nolast", e, 1'b1);
    r_last_cfg = 1'b1;
    do_txn(0, 64'h40, 8'h00, 64'd0, rd, e);
    chk("ok_after_err", e, 1'b0);

    // Request held high across a busy read.
    @(negedge clk);
    req = 1; we = 0; addr = 64'h40;
    #1 chk("h_gnt_c0", gnt, 1'b1);
    @(negedge clk);
    addr = 64'h48;
    #1 chk("h_gnt_c1", gnt, 1'b0);
    @(negedge clk);
    #1 chk("h_gnt_c2", gnt, 1'b0);
    @(negedge clk);
    #1 chk("h_c3_rvalid", rvalid, 1'b1);
    chk("h_c3_gnt", gnt, 1'b1);
    chk("h_c3_data", rdata, 64'hDEADBEEF_CAFEF00D);
    @(negedge clk);
    req = 0;
    #1 chk("h_c4_ar", {axi_ar_valid, gnt}, 2'b10);
    chk("h_c4_addr", axi_ar_addr, 64'h48);
    @(negedge clk);
    @(negedge clk);
    #1 chk("h_c6_rvalid", rvalid, 1'b1);
    chk("h_c6_data", rdata, 64'h00000000_55667788);

    // Reset while waiting in RD_RESP.
    r_hold = 1;
    @(negedge clk);
    req = 1; we = 0; addr = 64'h40;
    #1 chk("x_gnt", gnt, 1'b1);
    @(negedge clk);
    req = 0;
    @(negedge clk);
    #1 chk("x_rresp_state", axi_r_ready, 1'b1);
    @(negedge clk);
    rst_n = 0;
    #1 chk("x_rst_ready_valid", {axi_ar_valid, axi_r_ready, rvalid}, 3'b000);
    chk("x_rst_data", rdata, 64'd0);
    slave_reset();
    @(negedge clk);
    rst_n = 1;
    #1 chk("x_after_rvalid", rvalid, 1'b0);
    do_txn(0, 64'h40, 8'h00, 64'd0, rd, e);
    chk("x_read_data", rd, 64'hDEADBEEF_CAFEF00D);
    chk("x_read_err", e, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
